// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the dff_bank_arbiter slice.
// The pick searches from last+1 upward and wraps modulo the requester count.
package dff_arb_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_REQ       = 32;
  localparam int IDX_W         = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // The owner itself is checked last, so any other requester always wins the pick.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] req_vec,
    input logic [IDX_W-1:0]   last_idx,
    input logic [IDX_W:0]     n_req
  );
    pick_t          res;
    logic [IDX_W:0] cand;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      cand = {1'b0, last_idx} + (IDX_W+1)'(k);
      if (cand >= n_req) begin
        cand = cand - n_req;
      end else begin
        cand = cand;
      end
      if (!res.found && (k <= int'(n_req)) && req_vec[cand[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[IDX_W-1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: request levels and data in,
// grant, owner, busy and the register's q/qb out.
interface dff_bank_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wr_data;
  logic [N_REQ-1:0]       gnt;
  logic [OW-1:0]          owner;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       qb;

  modport master (
    output req, wr_data,
    input  gnt, owner, busy, q, qb
  );

  modport slave (
    input  req, wr_data,
    output gnt, owner, busy, q, qb
  );
endinterface

// File: rtl/dff_bank_arbiter_reg.sv
// WIDTH-bit shared storage register with load enable and a complemented output.
// qb is derived from the same flops so it can never disagree with q.
module dff_reg
  import dff_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qb_o
);
  logic [WIDTH-1:0] q_q;

  // Storage flops: cleared asynchronously, loaded only while the owner writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o  = q_q;
  assign qb_o = ~q_q;
endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register (dff_reg).
// Define DFF_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when others wait.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  dff_bank_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] GNT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  if ((N_REQ < 2) || (N_REQ > MAX_REQ) || (MAX_HOLD < 1)) begin : g_bad_cfg
    $error("dff_bank_arbiter: unsupported N_REQ/MAX_HOLD configuration");
  end

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_q, last_d;
  logic             busy_q, busy_d;

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
`endif

  pick_t            pick_s;
  logic [OW-1:0]    pick_idx_s;
  logic             unused_pick_s;
  logic             own_req_s;
  logic             others_s;
  logic             take_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] wr_slice_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] qb_s;

  assign pick_s        = rr_pick(MAX_REQ'(bus.req), IDX_W'(last_q), (IDX_W+1)'(N_REQ));
  assign pick_idx_s    = pick_s.idx[OW-1:0];
  assign unused_pick_s = ^pick_s.idx;
  assign own_req_s     = bus.req[owner_q];
  assign others_s      = |(bus.req & ~gnt_q);
  assign wr_en_s       = (state_q == BUSY) && own_req_s;

  // Select the owner's slice of the packed write bus.
  always_comb begin
    wr_slice_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        wr_slice_s = bus.wr_data[i*WIDTH +: WIDTH];
      end else begin
        wr_slice_s = wr_slice_s;
      end
    end
  end

  // Next-state decode; a release hands off straight to the next pick without an idle bubble.
  always_comb begin
    take_s  = 1'b0;
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef DFF_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_s.found) begin
          take_s = 1'b1;
        end else begin
          take_s = 1'b0;
        end
      end
      BUSY: begin
        if (!own_req_s) begin
          if (pick_s.found) begin
            take_s = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else begin
`ifdef DFF_ARB_TIMEOUT_EN
          if ((hold_cnt_q == HOLD_MAX) && others_s) begin
            take_s = 1'b1;
          end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
`else
          take_s = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (take_s) begin
      state_d = BUSY;
      gnt_d   = GNT_ONE << pick_idx_s;
      owner_d = pick_idx_s;
      last_d  = pick_idx_s;
`ifdef DFF_ARB_TIMEOUT_EN
      hold_cnt_d = '0;
`endif
      busy_d  = 1'b1;
    end else begin
      busy_d  = |gnt_d;
    end
  end

  // Arbiter FSM state and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(N_REQ - 1);
      busy_q  <= 1'b0;
`ifdef DFF_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
`ifdef DFF_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // others_s only steers preemption; keep it observed in the default build too.
  logic unused_others_s;
  assign unused_others_s = others_s;

  dff_reg #(.WIDTH(WIDTH)) u_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (wr_en_s),
    .d_i  (wr_slice_s),
    .q_o  (q_s),
    .qb_o (qb_s)
  );

  assign bus.gnt   = gnt_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.q     = q_s;
  assign bus.qb    = qb_s;
endmodule
